// File: rtl/dmem_lsu_pkg.sv
// Shared encodings and lane helpers for the DMem load/store unit.
// Big-endian lanes: byte offset 0 is bits [31:24].
package dmem_lsu_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STORE,
      ST_RMW_RD,
      ST_RMW_WR,
      ST_RESP
   } state_e;

   // Lane-enable bit i covers bits [8i+7:8i]; offset 0 lands on lane 3.
   localparam logic [3:0] LANE_BYTE = 4'b1000;
   localparam logic [3:0] LANE_HALF = 4'b1100;
   localparam logic [3:0] LANE_WORD = 4'b1111;

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: lane_mask = LANE_BYTE >> off;
         SIZE_HALF: lane_mask = LANE_HALF >> off;
         default:   lane_mask = LANE_WORD;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_HALF: is_misaligned = off[0];
         SIZE_BYTE: is_misaligned = 1'b0;
         default:   is_misaligned = |off;
      endcase
   endfunction

   function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: align_offset = off;
         SIZE_HALF: align_offset = {off[1], 1'b0};
         default:   align_offset = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational lane logic: load extraction/extension and store lane merge.
module dmem_lane_merge
   import dmem_lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] load_val,
   output logic [31:0] store_word
);

   logic [31:0] shifted;
   logic [31:0] rep;
   logic [3:0]  mask;
   logic        sign;

   // Shift the addressed lane(s) up to the top so extraction is offset-free.
   assign shifted = word << {off, 3'b000};
   assign sign    = ~uns & shifted[31];
   assign mask    = lane_mask(size, off);

   always_comb begin
      load_val = shifted;
      rep      = wdata;
      case (size)
         SIZE_BYTE: begin
            load_val = {{24{sign}}, shifted[31:24]};
            rep      = {4{wdata[7:0]}};
         end
         SIZE_HALF: begin
            load_val = {{16{sign}}, shifted[31:16]};
            rep      = {2{wdata[15:0]}};
         end
         default: begin
            load_val = word;
            rep      = wdata;
         end
      endcase
   end

   always_comb begin
      store_word = word;
      for (int i = 0; i < 4; i++) begin
         store_word[8*i +: 8] = mask[i] ? rep[8*i +: 8] : word[8*i +: 8];
      end
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator between the CPU MEM stage and word-addressed DMem.
// DMEM_LSU_ALIGN_TRAP_EN: trap misaligned accesses (RespErr) instead of force-aligning them.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 32
)
(
   input  logic                     Clk,
   input  logic                     Rst_n,
   input  logic                     ReqValid,
   output logic                     ReqReady,
   input  logic                     ReqWrite,
   input  logic [1:0]               ReqSize,
   input  logic                     ReqUnsigned,
   input  logic [31:0]              ReqAddr,
   input  logic [DATA_WIDTH-1:0]    ReqWData,
   output logic                     RespValid,
   output logic [DATA_WIDTH-1:0]    RespData,
   output logic                     RespErr,
   output logic [ADDRESS_WIDTH-1:0] MemAddress,
   output logic [DATA_WIDTH-1:0]    MemWriteData,
   output logic                     MemWrite,
   input  logic [DATA_WIDTH-1:0]    MemData
);

   state_e                state, next_state;
   logic [1:0]            size_q, off_q, req_size, req_off;
   logic                  uns_q, req_mis, accept;
   logic [DATA_WIDTH-1:0] load_val, store_word;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^ReqAddr[31:ADDRESS_WIDTH+2];
   assign req_size = (ReqSize == SIZE_RSVD) ? SIZE_WORD : ReqSize;
   assign accept   = ReqValid && (state == ST_IDLE);
   assign ReqReady = (state == ST_IDLE);
   assign RespValid = (state == ST_RESP);

`ifdef DMEM_LSU_ALIGN_TRAP_EN
   assign req_mis = is_misaligned(req_size, ReqAddr[1:0]);
   assign req_off = ReqAddr[1:0];

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)      RespErr <= 1'b0;
      else if (accept) RespErr <= req_mis;
   end
`else
   assign req_mis = 1'b0;
   assign req_off = align_offset(req_size, ReqAddr[1:0]);
   assign RespErr = 1'b0;
`endif

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (ReqValid) begin
               if (req_mis)                 next_state = ST_RESP;
               else if (!ReqWrite)          next_state = ST_LOAD;
               else if (req_size == SIZE_WORD) next_state = ST_STORE;
               else                         next_state = ST_RMW_RD;
            end
         end
         ST_LOAD:   next_state = ST_RESP;
         ST_STORE:  next_state = ST_RESP;
         ST_RMW_RD: next_state = ST_RMW_WR;
         ST_RMW_WR: next_state = ST_RESP;
         ST_RESP:   next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // MemWriteData doubles as the held store data until the RMW read returns.
   dmem_lane_merge u_merge (
      .word       (MemData),
      .wdata      (MemWriteData),
      .off        (off_q),
      .size       (size_q),
      .uns        (uns_q),
      .load_val   (load_val),
      .store_word (store_word)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state        <= ST_IDLE;
         MemWrite     <= 1'b0;
         MemAddress   <= '0;
         MemWriteData <= '0;
         RespData     <= '0;
      end else begin
         state    <= next_state;
         MemWrite <= (next_state == ST_STORE) || (next_state == ST_RMW_WR);
         if (accept) begin
            MemAddress <= ReqAddr[ADDRESS_WIDTH+1:2];
            if (ReqWrite && !req_mis) MemWriteData <= ReqWData;
         end
         if (state == ST_RMW_RD) MemWriteData <= store_word;
         if (state == ST_LOAD)   RespData     <= load_val;
      end
   end

   always_ff @(posedge Clk) begin
      if (accept) begin
         size_q <= req_size;
         off_q  <= req_off;
         uns_q  <= ReqUnsigned;
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu with a behavioural DMem and a response scoreboard.
module tb_dmem_lsu;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        ReqValid, ReqReady, ReqWrite, ReqUnsigned;
   logic [1:0]  ReqSize;
   logic [31:0] ReqAddr, ReqWData;
   logic        RespValid, RespErr, MemWrite;
   logic [31:0] RespData, MemWriteData, MemData;
   logic [15:0] MemAddress;

   always #5 Clk = ~Clk;

   dmem_lsu #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
      .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned), .ReqAddr(ReqAddr),
      .ReqWData(ReqWData), .RespValid(RespValid), .RespData(RespData),
      .RespErr(RespErr), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
      .MemWrite(MemWrite), .MemData(MemData)
   );

   logic [31:0] mem [0:65535];
   int          wr_count = 0;
   logic [15:0] last_wr_addr = '0;

   assign MemData = mem[MemAddress];

   always @(posedge Clk) begin
      if (MemWrite) begin
         mem[MemAddress] <= MemWriteData;
         wr_count        <= wr_count + 1;
         last_wr_addr    <= MemAddress;
      end
   end

   typedef struct {
      string       name;
      logic [31:0] data;
      logic        chk_data;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
      ReqValid    = 1'b1;
      ReqWrite    = w;
      ReqSize     = sz;
      ReqUnsigned = u;
      ReqAddr     = a;
      ReqWData    = wd;
   endtask

   task automatic push(input string name, input logic w, input logic [31:0] ed,
                       input logic ee, input int el);
      exp_t e;
      e.name = name; e.data = ed; e.chk_data = !w && !ee; e.err = ee; e.lat = el;
      sb_q.push_back(e);
   endtask

   // Called at a negedge with ReqValid held; returns at the negedge after the accept edge.
   task automatic accept(input string name);
      int k = 0;
      while (!ReqReady && k < 20) begin
         @(negedge Clk);
         k++;
      end
      n_checks++;
      if (!ReqReady) begin
         n_fail++;
         $display("FAIL %s accept: ReqReady=%b after %0d cycles, required 1", name, ReqReady, k);
      end
      @(posedge Clk);
      @(negedge Clk);
      ReqValid = 1'b0;
   endtask

   task automatic send(input string name, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee, input int el);
      push(name, w, ed, ee, el);
      @(negedge Clk);
      drive(w, sz, u, a, wd);
      accept(name);
   endtask

   task automatic collect();
      int   cnt = 1;
      exp_t e;
      while (!RespValid && cnt < 12) begin
         @(negedge Clk);
         cnt++;
      end
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard: response with empty queue, RespValid=%b", RespValid);
      end else begin
         e = sb_q.pop_front();
         if (!RespValid) begin
            n_fail++;
            $display("FAIL %s resp: RespValid=0 after %0d cycles, required 1", e.name, cnt);
         end else begin
            if (cnt !== e.lat) begin
               n_fail++;
               $display("FAIL %s latency: got %0d cycles, required %0d", e.name, cnt, e.lat);
            end
            n_checks++;
            if (RespErr !== e.err) begin
               n_fail++;
               $display("FAIL %s err: got %b, required %b", e.name, RespErr, e.err);
            end
            if (e.chk_data) begin
               n_checks++;
               if (RespData !== e.data) begin
                  n_fail++;
                  $display("FAIL %s data: got %h, required %h", e.name, RespData, e.data);
               end
            end
         end
      end
      @(negedge Clk);
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   task automatic test_reset();
      int w0;
      Rst_n = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00;
      ReqUnsigned = 1'b0; ReqAddr = '0; ReqWData = '0;
      #2 Rst_n = 1'b0;
      #1;
      check_val("rst ReqReady", {31'b0, ReqReady}, 32'd1);
      check_val("rst RespValid", {31'b0, RespValid}, 32'd0);
      check_val("rst RespData", RespData, 32'd0);
      check_val("rst RespErr", {31'b0, RespErr}, 32'd0);
      check_val("rst MemAddress", {16'b0, MemAddress}, 32'd0);
      check_val("rst MemWriteData", MemWriteData, 32'd0);
      check_val("rst MemWrite", {31'b0, MemWrite}, 32'd0);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      send("rst sw", 1'b1, 2'b10, 1'b0, 32'h20, 32'h01020304, 32'h0, 1'b0, 2);
      collect();
      w0 = wr_count;
      @(negedge Clk);
      drive(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000FF);
      accept("rst sb");
      Rst_n = 1'b0;
      #1;
      check_val("rst mid MemWrite", {31'b0, MemWrite}, 32'd0);
      check_val("rst mid ReqReady", {31'b0, ReqReady}, 32'd1);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      repeat (3) @(negedge Clk);
      check_val("rst mid writes", wr_count - w0, 32'd0);
      check_val("rst mid word8", mem[8], 32'h01020304);
   endtask

   task automatic test_word();
      int w0 = wr_count;
      send("sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
      collect();
      check_val("sw writes", wr_count - w0, 32'd1);
      check_val("sw addr", {16'b0, last_wr_addr}, 32'd4);
      send("lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
      collect();
   endtask

   task automatic test_byte();
      int w0;
      send("sw init", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 2);
      collect();
      w0 = wr_count;
      send("sb", 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 32'h0, 1'b0, 3);
      collect();
      check_val("sb writes", wr_count - w0, 32'd1);
      check_val("sb word4", mem[4], 32'h1122AA44);
      send("lb", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
      collect();
      send("lbu", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'h000000AA, 1'b0, 2);
      collect();
      send("lb pos", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000044, 1'b0, 2);
      collect();
   endtask

   task automatic test_half();
      send("sw zero", 1'b1, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 2);
      collect();
      send("sh", 1'b1, 2'b01, 1'b0, 32'h14, 32'h00008001, 32'h0, 1'b0, 3);
      collect();
      check_val("sh word5", mem[5], 32'h80010000);
      send("lh", 1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 32'hFFFF8001, 1'b0, 2);
      collect();
      send("lhu", 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 32'h00000000, 1'b0, 2);
      collect();
   endtask

   task automatic test_misaligned();
      int w0 = wr_count;
`ifdef DMEM_LSU_ALIGN_TRAP_EN
      send("lw mis", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1);
      collect();
      send("sh mis", 1'b1, 2'b01, 1'b0, 32'h17, 32'h0000BEEF, 32'h0, 1'b1, 1);
      collect();
      check_val("mis writes", wr_count - w0, 32'd0);
      check_val("mis word5", mem[5], 32'h80010000);
`else
      send("lw mis", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h1122AA44, 1'b0, 2);
      collect();
      send("sh mis", 1'b1, 2'b01, 1'b0, 32'h17, 32'h0000BEEF, 32'h0, 1'b0, 3);
      collect();
      check_val("mis writes", wr_count - w0, 32'd1);
      check_val("mis word5", mem[5], 32'h8001BEEF);
`endif
   endtask

   task automatic test_wrap();
      send("sw wrap", 1'b1, 2'b10, 1'b0, 32'h00040018, 32'hCAFEF00D, 32'h0, 1'b0, 2);
      collect();
      check_val("wrap addr", {16'b0, last_wr_addr}, 32'd6);
      send("lw wrap", 1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 32'hCAFEF00D, 1'b0, 2);
      collect();
      send("lw rsvd", 1'b0, 2'b11, 1'b0, 32'h18, 32'h0, 32'hCAFEF00D, 1'b0, 2);
      collect();
   endtask

   task automatic test_back_to_back();
      send("busy sb", 1'b1, 2'b00, 1'b0, 32'h13, 32'h00000055, 32'h0, 1'b0, 3);
      push("busy lw", 1'b0, 32'h1122AA55, 1'b0, 2);
      drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      check_val("busy ReqReady", {31'b0, ReqReady}, 32'd0);
      collect();
      accept("busy lw");
      collect();
      check_val("busy queue", sb_q.size(), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_misaligned();
      test_wrap();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
